// File: rtl/wide_narrow_serializer_if.sv
// Handshake bundle between the byte-striping stage and the per-lane encoder.
// Wide side: data_in/valid_in/ready_in. Narrow side: data_out/valid_out/ready_out/last_out.
// slave  : the serializer (consumes wide words, produces narrow beats)
// master : the surrounding logic (produces wide words, consumes narrow beats)
interface wide_narrow_serializer_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 8
);
    logic [IN_W-1:0]  data_in;
    logic             valid_in;
    logic             ready_in;
    logic [OUT_W-1:0] data_out;
    logic             valid_out;
    logic             ready_out;
    logic             last_out;

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_in,
        output data_out,
        output valid_out,
        input  ready_out,
        output last_out
    );

    modport master (
        output data_in,
        output valid_in,
        input  ready_in,
        input  data_out,
        input  valid_out,
        output ready_out,
        input  last_out
    );
endinterface

// File: rtl/wide_narrow_serializer.sv
// Wide-to-narrow lane serializer: slices each IN_W-bit word into IN_W/OUT_W beats
// on clk_4f, with a one-word prefetch buffer so a new word can be taken while the
// current one is still being shifted out.
// Ports:
//   clk_4f : fast lane clock, all state on its rising edge
//   reset  : synchronous, active-low
//   bus    : slave side of wide_narrow_serializer_if (IN_W/OUT_W must match the
//            interface instance parameters)
module wide_narrow_serializer #(
    parameter int unsigned      IN_W      = 32,
    parameter int unsigned      OUT_W     = 8,
    parameter bit               MSB_FIRST = 1'b1,
    parameter logic [OUT_W-1:0] IDLE_VAL  = '0
) (
    input  logic                     clk_4f,
    input  logic                     reset,
    wide_narrow_serializer_if.slave  bus
);

    localparam int unsigned      RATIO    = IN_W / OUT_W;
    localparam int unsigned      CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    // Reject widths that do not divide into at least two beats.
    if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_param_check
        $error("wide_narrow_serializer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
    end

    logic [IN_W-1:0]  cur_q, cur_d;
    logic [IN_W-1:0]  nxt_q, nxt_d;
    logic             cur_full_q, cur_full_d;
    logic             nxt_full_q, nxt_full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             adv;
    logic             last_beat;
    logic             fin;
    logic [CNT_W-1:0] slice_idx;
    logic [OUT_W-1:0] beat;

    // Per-cycle handshake events.
    always_comb begin
        accept    = bus.valid_in && !nxt_full_q;
        adv       = cur_full_q && bus.ready_out;
        last_beat = (cnt_q == LAST_CNT);
        fin       = adv && last_beat;
    end

    // Beat counter and word movement between input, prefetch and current registers.
    always_comb begin
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        cur_full_d = cur_full_q;
        nxt_full_d = nxt_full_q;
        cnt_d      = cnt_q;

        if (adv) begin
            cnt_d = fin ? '0 : cnt_q + CNT_W'(1);
        end

        if (!cur_full_q) begin
            // nxt is never occupied while cur is empty, so the word lands in cur.
            if (accept) begin
                cur_d      = bus.data_in;
                cur_full_d = 1'b1;
            end
        end else if (fin) begin
            if (nxt_full_q) begin
                cur_d      = nxt_q;
                nxt_full_d = 1'b0;
            end else if (accept) begin
                // Bypass the prefetch register so the next word starts without a bubble.
                cur_d = bus.data_in;
            end else begin
                cur_full_d = 1'b0;
            end
        end else if (accept) begin
            nxt_d      = bus.data_in;
            nxt_full_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            cur_q      <= '0;
            nxt_q      <= '0;
            cur_full_q <= 1'b0;
            nxt_full_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            cur_full_q <= cur_full_d;
            nxt_full_q <= nxt_full_d;
            cnt_q      <= cnt_d;
        end
    end

    // Select the current beat; slice 0 is the LSB slice, so MSB-first walks downward.
    always_comb begin
        slice_idx = MSB_FIRST ? (LAST_CNT - cnt_q) : cnt_q;
        beat      = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (slice_idx == CNT_W'(i)) begin
                beat = cur_q[i*OUT_W +: OUT_W];
            end
        end
    end

    // Outputs decode only registered state.
    assign bus.ready_in  = !nxt_full_q;
    assign bus.valid_out = cur_full_q;
    assign bus.last_out  = cur_full_q && last_beat;
    assign bus.data_out  = cur_full_q ? beat : IDLE_VAL;

endmodule

// File: tb/tb_wide_narrow_serializer.sv
// Bench for wide_narrow_serializer: a 32->8 MSB-first instance and a 16->4 LSB-first
// instance (idle value F), each compared every cycle against a word-queue model.
module tb_wide_narrow_serializer;

    logic clk_4f = 1'b0;
    logic reset;

    always #5 clk_4f = ~clk_4f;

    wide_narrow_serializer_if #(.IN_W(32), .OUT_W(8)) bus_a ();
    wide_narrow_serializer_if #(.IN_W(16), .OUT_W(4)) bus_b ();

    wide_narrow_serializer #(
        .IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1), .IDLE_VAL(8'h00)
    ) dut_a (
        .clk_4f(clk_4f),
        .reset (reset),
        .bus   (bus_a)
    );

    wide_narrow_serializer #(
        .IN_W(16), .OUT_W(4), .MSB_FIRST(1'b0), .IDLE_VAL(4'hF)
    ) dut_b (
        .clk_4f(clk_4f),
        .reset (reset),
        .bus   (bus_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Beat idx of a word, computed by shifting the word right by the slice position.
    function automatic logic [31:0] beat_of(input logic [31:0] word, input int unsigned idx,
                                            input int unsigned in_w, input int unsigned out_w,
                                            input bit msb_first);
        int unsigned ratio;
        int unsigned pos;
        ratio = in_w / out_w;
        pos   = msb_first ? (ratio - 1 - idx) : idx;
        return (word >> (pos * out_w)) & ((32'd1 << out_w) - 32'd1);
    endfunction

    // Model: queue of words held by the block; front word is being sent, bi beats done.
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    int unsigned bi_a = 0;
    int unsigned bi_b = 0;

    always @(negedge clk_4f) begin : mon_a
        logic acc;
        logic adv;
        check("a_valid", 32'(bus_a.valid_out), 32'(q_a.size() > 0));
        check("a_ready", 32'(bus_a.ready_in), 32'(q_a.size() < 2));
        if (q_a.size() > 0) begin
            check("a_data", 32'(bus_a.data_out), beat_of(q_a[0], bi_a, 32, 8, 1'b1));
            check("a_last", 32'(bus_a.last_out), 32'(bi_a == 3));
        end else begin
            check("a_idle", 32'(bus_a.data_out), 32'h0);
            check("a_last_idle", 32'(bus_a.last_out), 32'h0);
        end
        if (!reset) begin
            q_a.delete();
            bi_a = 0;
        end else begin
            adv = (q_a.size() > 0) && bus_a.ready_out;
            acc = bus_a.valid_in && (q_a.size() < 2);
            if (adv) begin
                if (bi_a == 3) begin
                    void'(q_a.pop_front());
                    bi_a = 0;
                end else begin
                    bi_a++;
                end
            end
            if (acc) q_a.push_back(bus_a.data_in);
        end
    end

    always @(negedge clk_4f) begin : mon_b
        logic acc;
        logic adv;
        check("b_valid", 32'(bus_b.valid_out), 32'(q_b.size() > 0));
        check("b_ready", 32'(bus_b.ready_in), 32'(q_b.size() < 2));
        if (q_b.size() > 0) begin
            check("b_data", 32'(bus_b.data_out), beat_of(q_b[0], bi_b, 16, 4, 1'b0));
            check("b_last", 32'(bus_b.last_out), 32'(bi_b == 3));
        end else begin
            check("b_idle", 32'(bus_b.data_out), 32'hF);
            check("b_last_idle", 32'(bus_b.last_out), 32'h0);
        end
        if (!reset) begin
            q_b.delete();
            bi_b = 0;
        end else begin
            adv = (q_b.size() > 0) && bus_b.ready_out;
            acc = bus_b.valid_in && (q_b.size() < 2);
            if (adv) begin
                if (bi_b == 3) begin
                    void'(q_b.pop_front());
                    bi_b = 0;
                end else begin
                    bi_b++;
                end
            end
            if (acc) q_b.push_back(32'(bus_b.data_in));
        end
    end

    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    // Offer a word to instance A; returns #1 after the edge that accepted it.
    task automatic a_send(input logic [31:0] w);
        logic rdy;
        rdy = 1'b0;
        bus_a.valid_in = 1'b1;
        bus_a.data_in  = w;
        for (int t = 0; t < 64; t++) begin
            rdy = bus_a.ready_in;
            step();
            if (rdy) begin
                bus_a.valid_in = 1'b0;
                return;
            end
        end
        check("a_send_timeout", 32'(rdy), 32'h1);
        bus_a.valid_in = 1'b0;
    endtask

    task automatic b_send(input logic [15:0] w);
        logic rdy;
        rdy = 1'b0;
        bus_b.valid_in = 1'b1;
        bus_b.data_in  = w;
        for (int t = 0; t < 64; t++) begin
            rdy = bus_b.ready_in;
            step();
            if (rdy) begin
                bus_b.valid_in = 1'b0;
                return;
            end
        end
        check("b_send_timeout", 32'(rdy), 32'h1);
        bus_b.valid_in = 1'b0;
    endtask

    task automatic a_wait_beat(input logic [7:0] v);
        logic hit;
        hit = 1'b0;
        for (int t = 0; t < 64; t++) begin
            hit = bus_a.valid_out && (bus_a.data_out == v);
            if (hit) return;
            step();
        end
        check("a_wait_timeout", 32'(hit), 32'h1);
    endtask

    logic [7:0] t2_beats [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] t4_beats [6] = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [3:0] t6_beats [4] = '{4'h4, 4'h3, 4'h2, 4'h1};

    initial begin
        reset           = 1'b0;
        bus_a.valid_in  = 1'b0;
        bus_a.data_in   = '0;
        bus_a.ready_out = 1'b1;
        bus_b.valid_in  = 1'b0;
        bus_b.data_in   = '0;
        bus_b.ready_out = 1'b1;

        // Reset sequence
        repeat (3) @(posedge clk_4f);
        #1 reset = 1'b1;
        step();
        check("rst_valid", 32'(bus_a.valid_out), 32'h0);
        check("rst_last", 32'(bus_a.last_out), 32'h0);
        check("rst_data", 32'(bus_a.data_out), 32'h00);
        check("rst_ready", 32'(bus_a.ready_in), 32'h1);
        check("rst_b_idle", 32'(bus_b.data_out), 32'hF);

        // Single word, first beat one cycle after accept
        a_send(32'hAABBCCDD);
        for (int k = 0; k < 4; k++) begin
            check("t2_beat", 32'(bus_a.data_out), 32'(t2_beats[k]));
            check("t2_last", 32'(bus_a.last_out), 32'(k == 3));
            step();
        end
        check("t2_end_valid", 32'(bus_a.valid_out), 32'h0);
        check("t2_end_data", 32'(bus_a.data_out), 32'h00);

        // Streaming three words: 12 gapless beats 01..0C
        fork
            begin
                a_send(32'h01020304);
                a_send(32'h05060708);
                a_send(32'h090A0B0C);
            end
            begin
                for (int t = 0; t < 16 && !bus_a.valid_out; t++) step();
                for (int k = 0; k < 12; k++) begin
                    check("t3_valid", 32'(bus_a.valid_out), 32'h1);
                    check("t3_beat", 32'(bus_a.data_out), 32'(k + 1));
                    check("t3_last", 32'(bus_a.last_out), 32'((k % 4) == 3));
                    step();
                end
            end
        join
        repeat (4) step();

        // Backpressure with a prefetched word
        a_send(32'h11223344);
        a_wait_beat(8'h22);
        bus_a.ready_out = 1'b0;
        bus_a.valid_in  = 1'b1;
        bus_a.data_in   = 32'h55667788;
        step();
        bus_a.valid_in = 1'b0;
        check("t4_ready_drop", 32'(bus_a.ready_in), 32'h0);
        check("t4_hold", 32'(bus_a.data_out), 32'h22);
        for (int k = 0; k < 2; k++) begin
            step();
            check("t4_hold", 32'(bus_a.data_out), 32'h22);
        end
        bus_a.ready_out = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t4_beat", 32'(bus_a.data_out), 32'(t4_beats[k]));
        end
        repeat (4) step();

        // Reset mid-word with the prefetch register occupied
        a_send(32'hAABBCCDD);
        a_send(32'h12345678);
        check("t5_pre_data", 32'(bus_a.data_out), 32'hBB);
        check("t5_pre_ready", 32'(bus_a.ready_in), 32'h0);
        reset = 1'b0;
        step();
        check("t5_rst_valid", 32'(bus_a.valid_out), 32'h0);
        check("t5_rst_data", 32'(bus_a.data_out), 32'h00);
        reset = 1'b1;
        step();
        check("t5_idle_valid", 32'(bus_a.valid_out), 32'h0);
        a_send(32'hCAFEF00D);
        check("t5_first", 32'(bus_a.data_out), 32'hCA);
        repeat (6) step();

        // LSB-first 16->4 instance
        b_send(16'h1234);
        for (int k = 0; k < 4; k++) begin
            check("t6_beat", 32'(bus_b.data_out), 32'(t6_beats[k]));
            check("t6_last", 32'(bus_b.last_out), 32'(k == 3));
            step();
        end
        check("t6_idle", 32'(bus_b.data_out), 32'hF);

        // Randomized traffic on both instances, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            bus_a.valid_in  = ($urandom_range(0, 3) != 0);
            bus_a.data_in   = $urandom;
            bus_a.ready_out = ($urandom_range(0, 3) != 0);
            bus_b.valid_in  = ($urandom_range(0, 2) != 0);
            bus_b.data_in   = 16'($urandom);
            bus_b.ready_out = ($urandom_range(0, 2) != 0);
            reset           = ($urandom_range(0, 299) != 0);
            step();
        end
        reset           = 1'b1;
        bus_a.valid_in  = 1'b0;
        bus_a.ready_out = 1'b1;
        bus_b.valid_in  = 1'b0;
        bus_b.ready_out = 1'b1;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
